// File: rtl/controller_sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker: FSM state encoding,
// Avalon word addresses of the ID/timestamp registers and the retry limit.
package controller_sysid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic       SYSID_ADDR_ID = 1'b0;
  localparam logic       SYSID_ADDR_TS = 1'b1;
  localparam logic [1:0] MAX_ATTEMPTS  = 2'd3;

endpackage

// File: rtl/controller_sysid_checker_if.sv
// Avalon-MM read-only bus between the checker (master) and the sysid slave.
interface controller_sysid_checker_if;

  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );

endinterface

// File: rtl/controller_sysid_checker_timeout.sv
// Per-read stall counter: counts enabled cycles and flags the cycle in which
// the stall count reaches TIMEOUT_CYCLES, so the FSM can give up on that edge.
module controller_sysid_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  // The current stalled cycle is the TIMEOUT_CYCLES-th one.
  assign expired = enable && (count_reg == LAST_COUNT);

endmodule

// File: rtl/controller_sysid_checker.sv
// Reads the system ID and timestamp over Avalon-MM and compares them with the
// expected values. Define SYSID_CHECKER_RETRY_EN to retry failed runs (3 attempts).
module controller_sysid_checker
  import controller_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000C001,
  parameter logic [31:0] EXPECTED_TS    = 32'd1533518009,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  controller_sysid_checker_if.master    avm,
  output logic                          busy,
  output logic                          done,
  output logic                          id_ok,
  output logic                          ts_ok,
  output logic                          timeout,
  output logic [1:0]                    attempts,
  output logic [31:0]                   id_value,
  output logic [31:0]                   ts_value
);

  state_t      state_reg, state_next;
  logic        done_reg, done_next;
  logic        id_ok_reg, id_ok_next;
  logic        ts_ok_reg, ts_ok_next;
  logic        timeout_reg, timeout_next;
  logic [1:0]  attempts_reg, attempts_next;
  logic [31:0] id_value_reg, id_value_next;
  logic [31:0] ts_value_reg, ts_value_next;

  logic in_read;
  logic stall_expired;
  logic can_retry;
  logic restart;
  logic give_up;
  logic id_match;
  logic ts_match;

  assign in_read = (state_reg == RD_ID) || (state_reg == RD_TS);

`ifdef SYSID_CHECKER_RETRY_EN
  assign can_retry = (attempts_reg < MAX_ATTEMPTS);
`else
  assign can_retry = 1'b0;
`endif

  // Leaving a read state (accept or timeout) or sitting outside one restarts the count.
  controller_sysid_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_read || !avm.avm_waitrequest || stall_expired),
    .enable  (in_read && avm.avm_waitrequest),
    .expired (stall_expired)
  );

  always_comb begin
    state_next    = state_reg;
    done_next     = 1'b0;
    id_ok_next    = id_ok_reg;
    ts_ok_next    = ts_ok_reg;
    timeout_next  = timeout_reg;
    attempts_next = attempts_reg;
    id_value_next = id_value_reg;
    ts_value_next = ts_value_reg;
    restart       = 1'b0;
    give_up       = 1'b0;
    id_match      = (id_value_reg == EXPECTED_ID);
    ts_match      = (ts_value_reg == EXPECTED_TS);

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = RD_ID;
          id_ok_next    = 1'b0;
          ts_ok_next    = 1'b0;
          timeout_next  = 1'b0;
          id_value_next = '0;
          ts_value_next = '0;
          attempts_next = 2'd1;
        end
      end
      RD_ID: begin
        if (stall_expired) begin
          restart = can_retry;
          give_up = !can_retry;
        end else if (!avm.avm_waitrequest) begin
          id_value_next = avm.avm_readdata;
          state_next    = RD_TS;
        end
      end
      RD_TS: begin
        if (stall_expired) begin
          restart = can_retry;
          give_up = !can_retry;
        end else if (!avm.avm_waitrequest) begin
          ts_value_next = avm.avm_readdata;
          state_next    = CHECK;
        end
      end
      CHECK: begin
        if (!(id_match && ts_match) && can_retry) begin
          restart = 1'b1;
        end else begin
          id_ok_next = id_match;
          ts_ok_next = ts_match;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (give_up) begin
      timeout_next = 1'b1;
      id_ok_next   = 1'b0;
      ts_ok_next   = 1'b0;
      done_next    = 1'b1;
      state_next   = IDLE;
    end

    // A retry starts from a clean slate, exactly like a fresh start.
    if (restart) begin
      state_next    = RD_ID;
      attempts_next = attempts_reg + 2'd1;
      id_ok_next    = 1'b0;
      ts_ok_next    = 1'b0;
      timeout_next  = 1'b0;
      id_value_next = '0;
      ts_value_next = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      done_reg     <= 1'b0;
      id_ok_reg    <= 1'b0;
      ts_ok_reg    <= 1'b0;
      timeout_reg  <= 1'b0;
      attempts_reg <= 2'd0;
      id_value_reg <= '0;
      ts_value_reg <= '0;
    end else begin
      state_reg    <= state_next;
      done_reg     <= done_next;
      id_ok_reg    <= id_ok_next;
      ts_ok_reg    <= ts_ok_next;
      timeout_reg  <= timeout_next;
      attempts_reg <= attempts_next;
      id_value_reg <= id_value_next;
      ts_value_reg <= ts_value_next;
    end
  end

  assign avm.avm_read    = in_read;
  assign avm.avm_address = (state_reg == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy            = (state_reg != IDLE);
  assign done            = done_reg;
  assign id_ok           = id_ok_reg;
  assign ts_ok           = ts_ok_reg;
  assign timeout         = timeout_reg;
  assign attempts        = attempts_reg;
  assign id_value        = id_value_reg;
  assign ts_value        = ts_value_reg;

endmodule

// File: tb/tb_controller_sysid_checker.sv
// Scoreboard bench for controller_sysid_checker: a configurable Avalon slave,
// a stimulus process that predicts each run's outcome, and a done monitor.
module tb_controller_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000C001;
  localparam logic [31:0] EXP_TS = 32'd1533518009;
  localparam int          TO     = 8;
`ifdef SYSID_CHECKER_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic [1:0]  attempts;
    int          latency;
    int          start_at;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [1:0]  attempts;
  logic [31:0] id_value, ts_value;

  controller_sysid_checker_if avm_bus ();

  controller_sysid_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .avm      (avm_bus),
    .busy     (busy),
    .done     (done),
    .id_ok    (id_ok),
    .ts_ok    (ts_ok),
    .timeout  (timeout),
    .attempts (attempts),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t last_exp;
  bit   have_last = 1'b0;

  // Slave configuration, set by the stimulus before each run.
  int          cfg_stall_id = 0;
  int          cfg_stall_ts = 0;
  logic [31:0] cfg_id = '0;
  logic [31:0] cfg_ts = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Avalon slave: stalls each new transfer by the configured number of cycles.
  int   stall_left = 0;
  int   run_stalls = 0;
  logic prev_read = 1'b0;
  logic prev_addr = 1'b0;
  logic prev_stalled = 1'b0;

  initial begin
    avm_bus.avm_waitrequest = 1'b0;
    avm_bus.avm_readdata    = '0;
  end

  always @(negedge clock) begin
    if (reset) begin
      prev_read               = 1'b0;
      prev_stalled            = 1'b0;
      run_stalls              = 0;
      avm_bus.avm_waitrequest = 1'b0;
    end else begin
      if (prev_stalled) begin
        if (run_stalls < TO) begin
          check("read_held_in_stall", {31'd0, avm_bus.avm_read}, 32'd1);
          check("addr_held_in_stall", {31'd0, avm_bus.avm_address}, {31'd0, prev_addr});
        end
`ifndef SYSID_CHECKER_RETRY_EN
        else check("read_low_after_timeout", {31'd0, avm_bus.avm_read}, 32'd0);
`endif
      end
      if (avm_bus.avm_read) begin
        if (!prev_read || !prev_stalled || (avm_bus.avm_address != prev_addr)) begin
          stall_left = avm_bus.avm_address ? cfg_stall_ts : cfg_stall_id;
          run_stalls = 0;
        end
        if (stall_left > 0) begin
          avm_bus.avm_waitrequest = 1'b1;
          avm_bus.avm_readdata    = $urandom;
          stall_left--;
          run_stalls++;
        end else begin
          avm_bus.avm_waitrequest = 1'b0;
          avm_bus.avm_readdata    = avm_bus.avm_address ? cfg_ts : cfg_id;
        end
      end else begin
        avm_bus.avm_waitrequest = 1'($urandom_range(0, 1));
        avm_bus.avm_readdata    = $urandom;
        run_stalls              = 0;
      end
      prev_read    = avm_bus.avm_read;
      prev_addr    = avm_bus.avm_address;
      prev_stalled = avm_bus.avm_read && avm_bus.avm_waitrequest;
    end
  end

  // Monitor: every done pulse consumes one prediction.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      check("no_done_in_reset", {31'd0, done}, 32'd0);
    end else if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending run (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("latency",  32'(cyc - e.start_at), 32'(e.latency));
        check("id_ok",    {31'd0, id_ok},   {31'd0, e.id_ok});
        check("ts_ok",    {31'd0, ts_ok},   {31'd0, e.ts_ok});
        check("timeout",  {31'd0, timeout}, {31'd0, e.timeout});
        check("id_value", id_value, e.id_value);
        check("ts_value", ts_value, e.ts_value);
        check("attempts", {30'd0, attempts}, {30'd0, e.attempts});
        $display("run done: lat=%0d id=%0h ts=%0h id_ok=%0d ts_ok=%0d to=%0d att=%0d",
                 cyc - e.start_at, id_value, ts_value, id_ok, ts_ok, timeout, attempts);
        last_exp  = e;
        have_last = 1'b1;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     {31'd0, busy},    32'd0);
    check({tag, "_done"},     {31'd0, done},    32'd0);
    check({tag, "_id_ok"},    {31'd0, id_ok},   32'd0);
    check({tag, "_ts_ok"},    {31'd0, ts_ok},   32'd0);
    check({tag, "_timeout"},  {31'd0, timeout}, 32'd0);
    check({tag, "_attempts"}, {30'd0, attempts}, 32'd0);
    check({tag, "_id_value"}, id_value, 32'd0);
    check({tag, "_ts_value"}, ts_value, 32'd0);
    check({tag, "_avm_read"}, {31'd0, avm_bus.avm_read}, 32'd0);
    check({tag, "_avm_addr"}, {31'd0, avm_bus.avm_address}, 32'd0);
  endtask

  task automatic run_txn(input int sid, input int sts, input logic [31:0] idd,
                         input logic [31:0] tsd, input bit extra_start);
    exp_t e;
    int   dur;
    int   n;
    bit   failed;
    if (sid >= TO) begin
      e.id_ok = 1'b0; e.ts_ok = 1'b0; e.timeout = 1'b1;
      e.id_value = '0; e.ts_value = '0;
      dur = TO;
    end else if (sts >= TO) begin
      e.id_ok = 1'b0; e.ts_ok = 1'b0; e.timeout = 1'b1;
      e.id_value = idd; e.ts_value = '0;
      dur = sid + 1 + TO;
    end else begin
      e.id_ok = (idd == EXP_ID); e.ts_ok = (tsd == EXP_TS); e.timeout = 1'b0;
      e.id_value = idd; e.ts_value = tsd;
      dur = sid + sts + 3;
    end
    failed     = e.timeout || !(e.id_ok && e.ts_ok);
    n          = (RETRY && failed) ? 3 : 1;
    e.attempts = 2'(n);
    e.latency  = 1 + n * dur;

    @(negedge clock);
    cfg_stall_id = sid;
    cfg_stall_ts = sts;
    cfg_id       = idd;
    cfg_ts       = tsd;
    if (have_last) begin
      check("hold_id_ok",    {31'd0, id_ok},   {31'd0, last_exp.id_ok});
      check("hold_ts_ok",    {31'd0, ts_ok},   {31'd0, last_exp.ts_ok});
      check("hold_timeout",  {31'd0, timeout}, {31'd0, last_exp.timeout});
      check("hold_id_value", id_value, last_exp.id_value);
      check("hold_ts_value", ts_value, last_exp.ts_value);
      check("hold_attempts", {30'd0, attempts}, {30'd0, last_exp.attempts});
    end
    start      = 1'b1;
    e.start_at = cyc;
    exp_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
    if (extra_start) begin
      repeat (2) @(negedge clock);
      check("busy_at_extra_start", {31'd0, busy}, 32'd1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    for (int i = 0; i < 600 && busy; i++) @(negedge clock);
    check("run_completes", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rid, rts;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    run_txn(0, 0, EXP_ID, EXP_TS, 1'b0);        // zero-wait, good values
    run_txn(3, 3, EXP_ID, EXP_TS, 1'b0);        // three stall cycles per read
    run_txn(0, 0, EXP_ID, 32'd0, 1'b0);         // bad timestamp
    run_txn(1000, 0, EXP_ID, EXP_TS, 1'b0);     // slave stuck on ID read
    run_txn(2, 1000, EXP_ID, EXP_TS, 1'b0);     // slave stuck on TS read
    run_txn(TO - 1, TO - 1, EXP_ID, EXP_TS, 1'b0); // longest stall that still succeeds
    run_txn(4, 4, EXP_ID, EXP_TS, 1'b1);        // start while busy is ignored

    for (int k = 0; k < 20; k++) begin
      rid = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
      rts = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
      run_txn(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), rid, rts, 1'b0);
    end

    // Reset in the middle of the timestamp read.
    @(negedge clock);
    cfg_stall_id = 0;
    cfg_stall_ts = 20;
    cfg_id       = EXP_ID;
    cfg_ts       = EXP_TS;
    start        = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 50 && !(avm_bus.avm_read && avm_bus.avm_address); i++) @(negedge clock);
    check("reached_rd_ts", {31'd0, avm_bus.avm_read && avm_bus.avm_address}, 32'd1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrun_reset");
    exp_q.delete();
    have_last = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("idle_after_reset", {31'd0, busy}, 32'd0);

    run_txn(1, 2, EXP_ID, EXP_TS, 1'b0);
    run_txn(0, 0, 32'h1234_5678, EXP_TS, 1'b0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller_sysid_checker.md
CONTROLLER_SYSID_CHECKER -- requirements
Module: controller_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000C001: system ID value expected at word address 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'd1533518009: timestamp value expected at word address 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum waitrequest stall per read; legal range 1..65535.
REQ-004 SHALL have port clock  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle request to run a check sequence.
REQ-007 SHALL have port avm_address  out  1  Avalon-MM word address: 0 = ID, 1 = timestamp.
REQ-008 SHALL have port avm_read  out  1  Avalon-MM read strobe.
REQ-009 SHALL have port avm_readdata  in  32  read data; valid in a cycle where avm_read=1 and avm_waitrequest=0.
REQ-010 SHALL have port avm_waitrequest  in  1  slave stall.
REQ-011 SHALL have ports busy (1), done (1, one-cycle pulse), id_ok (1), ts_ok (1), timeout (1), attempts (2), all outputs.
REQ-012 SHALL have ports id_value and ts_value, both out, 32 bits: last captured ID and timestamp.

Function
REQ-013 SHALL implement FSM states IDLE, RD_ID, RD_TS, CHECK.
REQ-014 SHALL move IDLE->RD_ID on start=1; start in any other state SHALL be ignored.
REQ-015 SHALL, on leaving IDLE, clear id_ok, ts_ok, timeout and id_value/ts_value, and set attempts=1.
REQ-016 SHALL drive avm_read=1 in RD_ID and RD_TS only, with avm_address=0 in RD_ID and 1 in RD_TS, held stable while avm_waitrequest=1.
REQ-017 SHALL treat a transfer as accepted in the cycle avm_read=1 and avm_waitrequest=0; capture avm_readdata into id_value (RD_ID->RD_TS) or ts_value (RD_TS->CHECK) on that edge.
REQ-018 SHALL, in CHECK (exactly one cycle), set id_ok=(id_value==EXPECTED_ID), ts_ok=(ts_value==EXPECTED_TS), pulse done=1, then return to IDLE.
REQ-019 SHALL give a zero-wait-state run start-to-done latency of 4 cycles: RD_ID, RD_TS, CHECK, then done registered high in the following cycle.
REQ-020 SHALL count stalled cycles in RD_ID/RD_TS; counter SHALL clear on each accepted transfer and on state entry.
REQ-021 SHALL, when the stall count reaches TIMEOUT_CYCLES, deassert avm_read next cycle, set timeout=1 and id_ok=ts_ok=0, pulse done, and return to IDLE without capturing data.
REQ-022 SHALL drive busy=1 in every state except IDLE.
REQ-023 SHALL hold id_ok, ts_ok, timeout, id_value, ts_value and attempts stable from done until the next accepted start.

Reset
REQ-024 SHALL, while reset=1, force state IDLE, avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, attempts=0, id_value=0, ts_value=0, stall counter=0.
REQ-025 SHALL abort any in-flight read immediately on reset assertion, with no done pulse.

Configuration
REQ-026 SHALL, with SYSID_CHECKER_RETRY_EN defined, restart at RD_ID instead of finishing when CHECK finds a mismatch or a timeout occurs, up to 3 attempts total; attempts increments per restart; done pulses only after the final attempt.
REQ-027 SHALL, without SYSID_CHECKER_RETRY_EN, perform a single attempt and hold attempts=1 after any run.

Structure
REQ-028 SHALL place the FSM state enum, SYSID_ADDR_ID=0, SYSID_ADDR_TS=1 and MAX_ATTEMPTS=3 in package controller_sysid_pkg.
REQ-029 SHALL implement the stall counter as sub-module controller_sysid_timeout (inputs: clear, enable; output: expired).

Verification
REQ-030 SHALL cover: zero-wait slave returning 49153/1533518009 -> done on 4th cycle after start, id_ok=1, ts_ok=1, timeout=0.
REQ-031 SHALL cover: waitrequest held 3 cycles on each read -> address/read stable throughout, correct values captured, id_ok=ts_ok=1.
REQ-032 SHALL cover: timestamp returns 0 -> id_ok=1, ts_ok=0, ts_value=0; with RETRY_EN, attempts=3 at done.
REQ-033 SHALL cover: waitrequest stuck high, TIMEOUT_CYCLES=8 -> timeout=1, done after 8 stalled cycles, avm_read low next cycle.
REQ-034 SHALL cover: reset asserted mid-RD_TS -> all outputs at reset values, no done pulse; start pulsed while busy -> ignored.
